lsu_dmem: RTL and testbench

LSU_DMEM -- requirements
Module: lsu_dmem

---
 rtl/lsu_dmem.sv | 113 +++++++++++
 tb/tb_lsu_dmem.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// Load/store data memory: byte/half/word accesses on a 32-bit word array with
// single-cycle load latency, lane-masked stores and misalignment fault reporting.
module lsu_dmem #(
    parameter int ADDR_W    = 12,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              err_o
);
    localparam int          DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              fault;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic              store_en;
    logic              valid_d, err_d;

    logic [31:0] rd_word_q;
    logic        valid_q, err_q, uns_q;
    logic [1:0]  lane_q, size_q;

    assign idx  = addr_i[ADDR_W-1:2];
    assign lane = addr_i[1:0];

    always_comb begin
        fault     = 1'b0;
        be        = 4'b0000;
        wdata_rep = wdata_i;
        unique case (size_i)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                fault     = lane[0];
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                fault = (lane != 2'b00);
                be    = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
        // Gating with rst_ni keeps stores presented during reset from landing.
        store_en = req_i & we_i & ~fault & rst_ni;
        valid_d  = req_i & ~we_i & ~fault;
        err_d    = req_i & fault;
    end

    // Memory array has no reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
        if (valid_d) begin
            rd_word_q <= mem_q[idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            lane_q  <= lane;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rd_word_q[{lane_q, 3'b000} +: 8];
        sel_half = rd_word_q[{lane_q[1], 4'b0000} +: 16];
        rdata_o  = 32'h0000_0000;
        if (valid_q) begin
            unique case (size_q)
                2'b00:   rdata_o = {{24{~uns_q & sel_byte[7]}}, sel_byte};
                2'b01:   rdata_o = {{16{~uns_q & sel_half[15]}}, sel_half};
                default: rdata_o = rd_word_q;
            endcase
        end
    end

    assign rvalid_o = valid_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: each request pushes its expected response,
// which is popped and compared one cycle later, right after the accepting edge.
module tb_lsu_dmem;
    localparam int ADDR_W = 12;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [1:0]        size_i = 2'b00;
    logic              unsigned_i = 1'b0;
    logic [31:0]       wdata_i = 32'h0;
    logic [31:0]       rdata_o;
    logic              rvalid_o;
    logic              err_o;

    lsu_dmem #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [1:0]        sz;
        logic              uns;
        logic [31:0]       wd;
        logic [31:0]       x;
    } rq_t;

    exp_t       exp_q[$];
    logic [7:0] model [0:(1<<ADDR_W)-1];
    int         checks = 0;
    int         errors = 0;

    function automatic logic is_fault(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [7:0]  b0, b1;
        b0 = model[a];
        if (sz == 2'b00) return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
        b1 = model[a + 1];
        if (sz == 2'b01) return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        return {model[a + 3], model[a + 2], b1, b0};
    endfunction

    // Drives one request for one cycle; the expected response is pushed now and
    // is visible on the outputs once the call returns.
    task automatic send(input rq_t r, input logic use_model);
        exp_t e;
        @(negedge clk_i);
        req_i = 1'b1; we_i = r.we; addr_i = r.a; size_i = r.sz;
        unsigned_i = r.uns; wdata_i = r.wd;
        e = '0;
        if (is_fault(r.sz, r.a)) begin
            e.e = 1'b1;
        end else if (r.we) begin
            if (r.sz == 2'b00) model[r.a] = r.wd[7:0];
            else if (r.sz == 2'b01) begin
                model[r.a] = r.wd[7:0]; model[r.a + 1] = r.wd[15:8];
            end else begin
                for (int k = 0; k < 4; k++) model[r.a + k] = r.wd[8*k +: 8];
            end
        end else begin
            e.v = 1'b1;
            e.d = use_model ? model_load(r.a, r.sz, r.uns) : r.x;
        end
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b e=%0b d=%h, expected all zero", rvalid_o, err_o, rdata_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_release_idle: got v=%0b e=%0b d=%h, expected all zero", rvalid_o, err_o, rdata_o);
        end
    endtask

    task automatic test_word_byte_half();
        rq_t  tbl[10];
        exp_t e;
        tbl[0] = '{1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 12'h012, 2'b00, 1'b0, 32'h7777_775A, 32'h0};
        tbl[3] = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'hDE5ABEEF};
        tbl[4] = '{1'b0, 12'h012, 2'b00, 1'b0, 32'h0, 32'h0000005A};
        tbl[5] = '{1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE};
        tbl[6] = '{1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 32'h000000DE};
        tbl[7] = '{1'b0, 12'h012, 2'b01, 1'b0, 32'h0, 32'hFFFFDE5A};
        tbl[8] = '{1'b0, 12'h012, 2'b01, 1'b1, 32'h0, 32'h0000DE5A};
        tbl[9] = '{1'b0, 12'h011, 2'b01, 1'b0, 32'h0, 32'h0};
        foreach (tbl[i]) begin
            send(tbl[i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({rvalid_o, err_o, rdata_o} !== e) begin
                errors++;
                $display("FAIL word_byte_half[%0d] addr=%h: got v=%0b e=%0b d=%h, expected v=%0b e=%0b d=%h",
                         i, tbl[i].a, rvalid_o, err_o, rdata_o, e.v, e.e, e.d);
            end
        end
    endtask

    task automatic test_faults();
        rq_t  tbl[7];
        exp_t e;
        tbl[0] = '{1'b1, 12'h014, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0};
        tbl[1] = '{1'b1, 12'h016, 2'b10, 1'b0, 32'h12345678, 32'h0};
        tbl[2] = '{1'b0, 12'h014, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D};
        tbl[3] = '{1'b1, 12'h016, 2'b01, 1'b0, 32'hAAAA_BEEF, 32'h0};
        tbl[4] = '{1'b0, 12'h014, 2'b10, 1'b0, 32'h0, 32'hBEEFF00D};
        tbl[5] = '{1'b0, 12'h014, 2'b11, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 12'h015, 2'b01, 1'b0, 32'h0000_1234, 32'h0};
        foreach (tbl[i]) begin
            send(tbl[i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({rvalid_o, err_o, rdata_o} !== e) begin
                errors++;
                $display("FAIL faults[%0d] addr=%h: got v=%0b e=%0b d=%h, expected v=%0b e=%0b d=%h",
                         i, tbl[i].a, rvalid_o, err_o, rdata_o, e.v, e.e, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        rq_t  tbl[10];
        exp_t e;
        tbl[0] = '{1'b1, 12'h000, 2'b10, 1'b0, 32'h11111111, 32'h0};
        tbl[1] = '{1'b1, 12'h004, 2'b10, 1'b0, 32'h22222222, 32'h0};
        tbl[2] = '{1'b1, 12'h3FC, 2'b10, 1'b0, 32'h33333333, 32'h0};
        tbl[3] = '{1'b1, 12'hFFC, 2'b10, 1'b0, 32'h44444444, 32'h0};
        tbl[4] = '{1'b0, 12'h000, 2'b10, 1'b0, 32'h0, 32'h11111111};
        tbl[5] = '{1'b0, 12'h004, 2'b10, 1'b0, 32'h0, 32'h22222222};
        tbl[6] = '{1'b0, 12'h3FC, 2'b10, 1'b0, 32'h0, 32'h33333333};
        tbl[7] = '{1'b0, 12'hFFC, 2'b10, 1'b0, 32'h0, 32'h44444444};
        tbl[8] = '{1'b1, 12'h020, 2'b10, 1'b0, 32'h0BADF00D, 32'h0};
        tbl[9] = '{1'b0, 12'h020, 2'b10, 1'b0, 32'h0, 32'h0BADF00D};
        foreach (tbl[i]) begin
            send(tbl[i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({rvalid_o, err_o, rdata_o} !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] addr=%h: got v=%0b e=%0b d=%h, expected v=%0b e=%0b d=%h",
                         i, tbl[i].a, rvalid_o, err_o, rdata_o, e.v, e.e, e.d);
            end
        end
        @(posedge clk_i); #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL idle_after_load: got v=%0b e=%0b d=%h, expected all zero", rvalid_o, err_o, rdata_o);
        end
    endtask

    task automatic test_reset_inflight();
        rq_t  r;
        exp_t e;
        r = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'hDE5ABEEF};
        send(r, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== e) begin
            errors++;
            $display("FAIL inflight_load: got v=%0b d=%h, expected v=%0b d=%h", rvalid_o, rdata_o, e.v, e.d);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL async_reset_clear: got v=%0b e=%0b d=%h, expected all zero", rvalid_o, err_o, rdata_o);
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; size_i = 2'b10; wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_held: got v=%0b e=%0b d=%h, expected all zero", rvalid_o, err_o, rdata_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL no_rvalid_after_release: got rvalid=%0b, expected 0", rvalid_o);
        end
        send(r, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== e) begin
            errors++;
            $display("FAIL load_after_reset: got v=%0b d=%h, expected v=%0b d=%h", rvalid_o, rdata_o, e.v, e.d);
        end
    endtask

    task automatic test_random();
        rq_t  r;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            r.we  = ($urandom_range(0, 2) == 0);
            r.a   = 12'h400 | ADDR_W'($urandom_range(0, 63));
            r.sz  = 2'($urandom_range(0, 3));
            r.uns = 1'($urandom_range(0, 1));
            r.wd  = $urandom;
            r.x   = 32'h0;
            send(r, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if ({rvalid_o, err_o, rdata_o} !== e) begin
                errors++;
                $display("FAIL random[%0d] we=%0b addr=%h sz=%0d uns=%0b: got v=%0b e=%0b d=%h, expected v=%0b e=%0b d=%h",
                         i, r.we, r.a, r.sz, r.uns, rvalid_o, err_o, rdata_o, e.v, e.e, e.d);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) model[k] = 8'h00;
        test_reset();
        test_word_byte_half();
        test_faults();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
